// File: rtl/segdac_mon_pkg.sv
// Shared constants and helpers for the SEGDAC thermometer-code monitor.
package segdac_mon_pkg;

    // Legal 3-bit thermometer codes for one 2-bit segment.
    localparam logic [2:0] THERMO_0 = 3'b000;
    localparam logic [2:0] THERMO_1 = 3'b001;
    localparam logic [2:0] THERMO_2 = 3'b011;
    localparam logic [2:0] THERMO_3 = 3'b111;

    localparam int unsigned SEGS_PER_CH = 4;
    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned SEG_BITS    = 3;
    localparam int unsigned CH_BITS     = SEGS_PER_CH * SEG_BITS;

    // Width needed to add n_bytes unsigned bytes without overflow.
    function automatic int unsigned byte_sum_w(input int unsigned n_bytes);
        return 8 + $clog2(n_bytes);
    endfunction

    localparam int unsigned SUM_W = byte_sum_w(NUM_CH);

endpackage

// File: rtl/thermo3_decode.sv
// Decodes one 3-bit thermometer segment to its 2-bit binary weight.
module thermo3_decode
    import segdac_mon_pkg::*;
(
    input  logic [2:0] thermo,
    output logic [1:0] bin,
    output logic       illegal
);

    // Non-thermometer codes decode to zero and raise the illegal flag.
    always_comb begin
        bin     = 2'd0;
        illegal = 1'b0;
        case (thermo)
            THERMO_0: bin = 2'd0;
            THERMO_1: bin = 2'd1;
            THERMO_2: bin = 2'd2;
            THERMO_3: bin = 2'd3;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/segdac_thermo_monitor.sv
// Receive-side checker: decodes thermometer R/G/B segment buses back to BGR pixels,
// flags illegal codes and keeps per-frame error count and additive checksum.
module segdac_thermo_monitor
    import segdac_mon_pkg::*;
#(
    parameter logic        VSYNC_ACTIVE = 1'b0,
    parameter int unsigned ERR_W        = 16,
    parameter int unsigned CHK_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CH_BITS-1:0] R,
    input  logic [CH_BITS-1:0] G,
    input  logic [CH_BITS-1:0] B,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               sample_en,
    output logic [23:0]        rgb_out,
    output logic               rgb_valid,
    output logic               code_err,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               frame_done,
    output logic [ERR_W-1:0]   frame_errs,
    output logic [CHK_W-1:0]   frame_chk,
    output logic [7:0]         frame_cnt
);

    // Stage 1 registers
    logic [CH_BITS-1:0] r1_q, g1_q, b1_q;
    logic               hs1_q, vs1_q, en1_q;
    // Previous stage-1 vsync, plus qualifiers that stay low until both vsync
    // history registers hold real post-reset samples.
    logic               vs_prev_q;
    logic               vld1_q, vld2_q;

    // Stage 2 / report registers
    logic [23:0]        rgb_q;
    logic               valid_q, err_q, hs2_q, vs2_q, done_q;
    logic [ERR_W-1:0]   frame_errs_q;
    logic [CHK_W-1:0]   frame_chk_q;
    logic [7:0]         frame_cnt_q;

    // Accumulators
    logic [ERR_W-1:0]   err_acc_q, err_acc_d;
    logic [CHK_W-1:0]   chk_acc_q, chk_acc_d;

    // Decode network
    logic [NUM_CH-1:0][CH_BITS-1:0]           seg_bus;
    logic [NUM_CH-1:0][7:0]                   dec_byte;
    logic [NUM_CH*SEGS_PER_CH-1:0]            seg_ill;
    logic                                     pix_err;
    logic                                     frame_edge;
    logic [SUM_W-1:0]                         pix_sum;

    assign seg_bus = {b1_q, g1_q, r1_q};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar s = 0; s < SEGS_PER_CH; s++) begin : g_seg
            thermo3_decode u_dec (
                .thermo  (seg_bus[c][SEG_BITS*s +: SEG_BITS]),
                .bin     (dec_byte[c][2*s +: 2]),
                .illegal (seg_ill[c*SEGS_PER_CH + s])
            );
        end
    end

    // Stage 1: capture buses and keep one cycle of vsync history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q      <= '0;
            g1_q      <= '0;
            b1_q      <= '0;
            hs1_q     <= 1'b0;
            vs1_q     <= ~VSYNC_ACTIVE;
            vs_prev_q <= ~VSYNC_ACTIVE;
            en1_q     <= 1'b0;
            vld1_q    <= 1'b0;
            vld2_q    <= 1'b0;
        end else begin
            r1_q      <= R;
            g1_q      <= G;
            b1_q      <= B;
            hs1_q     <= hsync;
            vs1_q     <= vsync;
            vs_prev_q <= vs1_q;
            en1_q     <= sample_en;
            vld1_q    <= 1'b1;
            vld2_q    <= vld1_q;
        end
    end

    // Pixel error, checksum contribution and frame-edge detection for stage 2.
    always_comb begin
        pix_err    = en1_q & (|seg_ill);
        pix_sum    = SUM_W'(dec_byte[0]) + SUM_W'(dec_byte[1]) + SUM_W'(dec_byte[2]);
        frame_edge = vld2_q && (vs1_q != vs_prev_q) && (vs1_q == VSYNC_ACTIVE);
    end

    // Accumulator next state; the pixel coincident with an edge opens the new frame.
    always_comb begin
        err_acc_d = err_acc_q;
        chk_acc_d = chk_acc_q;
        if (frame_edge) begin
            err_acc_d = ERR_W'(pix_err);
            chk_acc_d = en1_q ? CHK_W'(pix_sum) : '0;
        end else if (en1_q) begin
            if (pix_err && (err_acc_q != {ERR_W{1'b1}})) begin
                err_acc_d = err_acc_q + ERR_W'(1);
            end
            chk_acc_d = chk_acc_q + CHK_W'(pix_sum);
        end
    end

    // Stage 2: registered pixel/sync outputs, accumulators and frame reports.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q        <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            hs2_q        <= 1'b0;
            vs2_q        <= 1'b0;
            done_q       <= 1'b0;
            err_acc_q    <= '0;
            chk_acc_q    <= '0;
            frame_errs_q <= '0;
            frame_chk_q  <= '0;
            frame_cnt_q  <= '0;
        end else begin
            if (en1_q) begin
                rgb_q <= dec_byte;
            end
            valid_q   <= en1_q;
            err_q     <= pix_err;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            done_q    <= frame_edge;
            err_acc_q <= err_acc_d;
            chk_acc_q <= chk_acc_d;
            if (frame_edge) begin
                frame_errs_q <= err_acc_q;
                frame_chk_q  <= chk_acc_q;
                frame_cnt_q  <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign rgb_out    = rgb_q;
    assign rgb_valid  = valid_q;
    assign code_err   = err_q;
    assign hsync_out  = hs2_q;
    assign vsync_out  = vs2_q;
    assign frame_done = done_q;
    assign frame_errs = frame_errs_q;
    assign frame_chk  = frame_chk_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
